// File: rtl/ip_codma_crc_sched.sv
// ip_codma_crc_sched: round-robin share of one CRC-16 engine among DMA channels.
// Arbitrates, latches the winner's block, starts the engine, times out, returns result.
// Ports:
//   clk_i, reset_i          clock, sync active-high reset
//   req_i, req_data_i       per-channel request level and 8x32 block
//   gnt_o, done_o           one-hot grant (LOAD..RESP), one-cycle completion pulse
//   crc_o, err_o            result and timeout flag, valid with done_o, held after
//   busy_o                  high outside IDLE
//   eng_start_o, eng_data_o engine start pulse and latched block
//   eng_done_i, eng_crc_i   engine completion and result
module ip_codma_crc_sched #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0][7:0][31:0]    req_data_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic [NUM_REQ-1:0]               done_o,
  output logic [15:0]                      crc_o,
  output logic                             err_o,
  output logic                             busy_o,
  output logic                             eng_start_o,
  output logic [7:0][31:0]                 eng_data_o,
  input  logic                             eng_done_i,
  input  logic [15:0]                      eng_crc_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_win;
  logic [IDX_W-1:0]      r_last;
  logic [IDX_W-1:0]      w_win;
  logic                  w_any;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_start;
  logic [7:0][31:0]      r_data;
  logic [15:0]           r_crc;
  logic                  r_err;
  logic                  w_tmo;
  logic                  w_acc;
  logic [NUM_REQ-1:0]    w_oh;

  // search from last winner + 1 upward, wrapping at NUM_REQ
  always_comb begin
    logic [IDX_W:0] v_idx;
    w_any = 1'b0;
    w_win = '0;
    v_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      v_idx = {1'b0, r_last} + (IDX_W+1)'(i);
      if (v_idx >= (IDX_W+1)'(NUM_REQ))
        v_idx = v_idx - (IDX_W+1)'(NUM_REQ);
      if (!w_any && req_i[v_idx[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = v_idx[IDX_W-1:0];
      end
    end
  end

  assign w_oh  = NUM_REQ'(1) << r_win;
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));
  // r_start marks the first RUN cycle, where completion is ignored
  assign w_acc = !r_start && (eng_done_i || w_tmo);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (w_acc) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    busy_o = (r_state != S_IDLE);
    if (r_state != S_IDLE) gnt_o  = w_oh;
    if (r_state == S_RESP) done_o = w_oh;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_win   <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_data  <= '0;
      r_crc   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) r_win <= w_win;
        end
        S_LOAD: begin
          r_data  <= req_data_i[r_win];
          r_start <= 1'b1;
          r_cnt   <= '0;
        end
        S_RUN: begin
          if (!r_start) begin
            r_cnt <= r_cnt + CNT_W'(1);
            // done has priority over a timeout in the same cycle
            if (eng_done_i) begin
              r_crc <= eng_crc_i;
              r_err <= 1'b0;
            end else if (w_tmo) begin
              r_crc <= '0;
              r_err <= 1'b1;
            end
          end
        end
        S_RESP: begin
          r_last <= r_win;
        end
        default: ;
      endcase
    end
  end

  assign eng_start_o = r_start;
  assign eng_data_o  = r_data;
  assign crc_o       = r_crc;
  assign err_o       = r_err;

endmodule
